// File: rtl/ddr4_cmd_monitor_if.sv
// rtl/ddr4_cmd_monitor_if.sv - fabric-side DDR4 command bus, 4 slots x 2 bits per signal byte
interface ddr4_cmd_monitor_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int BANK_WIDTH = 2,
    parameter int BG_WIDTH   = 2,
    parameter int CS_WIDTH   = 1,
    parameter int CKE_WIDTH  = 1
);
    logic [7:0]              mc_ACT_n;
    logic [ADDR_WIDTH*8-1:0] mc_ADR;
    logic [BANK_WIDTH*8-1:0] mc_BA;
    logic [BG_WIDTH*8-1:0]   mc_BG;
    logic [CS_WIDTH*8-1:0]   mc_CS_n;
    logic [CKE_WIDTH*8-1:0]  mc_CKE;

    modport master (output mc_ACT_n, mc_ADR, mc_BA, mc_BG, mc_CS_n, mc_CKE);
    modport slave  (input  mc_ACT_n, mc_ADR, mc_BA, mc_BG, mc_CS_n, mc_CKE);
endinterface

// File: rtl/ddr4_cmd_monitor.sv
// rtl/ddr4_cmd_monitor.sv - passive DDR4 command decoder with MR1/self-refresh tracking and timing checks
module ddr4_cmd_monitor #(
    parameter int          ADDR_WIDTH = 17,
    parameter int          BANK_WIDTH = 2,
    parameter int          BG_WIDTH   = 2,
    parameter int          CS_WIDTH   = 1,
    parameter int          CKE_WIDTH  = 1,
    parameter int          T_MOD      = 24,
    parameter int          T_XS       = 1000,
    parameter logic [13:0] MR1_RST    = 14'h0001
) (
    input  logic                  clk,
    input  logic                  rst,
    ddr4_cmd_monitor_if.slave     bus,
    input  logic                  viol_clr,
    output logic [3:0]            cmd_vld,
    output logic [15:0]           cmd_code,
    output logic                  srx_pulse,
    output logic                  sr_active,
    output logic [13:0]           mr1_q,
    output logic                  dll_on,
    output logic                  viol_tmod,
    output logic                  viol_txs,
    output logic                  viol_sr
);
    localparam logic [3:0] C_DES = 4'h0, C_ACT = 4'h1, C_PRE = 4'h2, C_PREA = 4'h3,
                           C_RD = 4'h4, C_WR = 4'h5, C_REF = 4'h6, C_SRE = 4'h7,
                           C_MRS = 4'h8, C_ZQC = 4'h9, C_RSVD = 4'hA;

    logic [3:0]  cmd_vld_q, vld_d;
    logic [15:0] cmd_code_q, code_d;
    logic        srx_q, srx_d, sr_q, sr_d, cke_last_q, cke_last_d;
    logic        viol_tmod_q, viol_txs_q, viol_sr_q;
    logic        set_tmod, set_txs, set_sr, mrs_any;
    logic [13:0] mr1_d;
    logic [15:0] mod_cnt_q, mod_cnt_d, xs_cnt_q, xs_cnt_d;

    logic        cke_prev, srx_seen, srx_edge, cs_n, act_n, cke, bg0;
    logic [1:0]  ba;
    logic [2:0]  rcw;
    logic [3:0]  code;
    logic [13:0] adr;

    logic [7:0]              unused_act;
    logic [ADDR_WIDTH*8-1:0] unused_adr;
    logic [BANK_WIDTH*8-1:0] unused_ba;
    logic [BG_WIDTH*8-1:0]   unused_bg;
    logic [CS_WIDTH*8-1:0]   unused_cs;
    logic [CKE_WIDTH*8-1:0]  unused_cke;
    assign unused_act = bus.mc_ACT_n;
    assign unused_adr = bus.mc_ADR;
    assign unused_ba  = bus.mc_BA;
    assign unused_bg  = bus.mc_BG;
    assign unused_cs  = bus.mc_CS_n;
    assign unused_cke = bus.mc_CKE;

    // Slots are walked in time order so SR entry/exit and same-cycle MRS affect later slots.
    always_comb begin
        vld_d    = '0;
        code_d   = '0;
        mr1_d    = mr1_q;
        sr_d     = sr_q;
        srx_d    = 1'b0;
        mrs_any  = 1'b0;
        set_tmod = 1'b0;
        set_txs  = 1'b0;
        set_sr   = 1'b0;
        cke_prev = cke_last_q;
        srx_seen = 1'b0;
        srx_edge = 1'b0;
        cs_n     = 1'b1;
        act_n    = 1'b1;
        cke      = 1'b1;
        bg0      = 1'b0;
        ba       = '0;
        rcw      = '1;
        code     = C_DES;
        adr      = '0;
        for (int k = 0; k < 4; k++) begin
            cs_n  = bus.mc_CS_n[2*k];
            act_n = bus.mc_ACT_n[2*k];
            cke   = bus.mc_CKE[2*k];
            bg0   = bus.mc_BG[2*k];
            ba    = {bus.mc_BA[8 + 2*k], bus.mc_BA[2*k]};
            rcw   = {bus.mc_ADR[16*8 + 2*k], bus.mc_ADR[15*8 + 2*k], bus.mc_ADR[14*8 + 2*k]};
            for (int j = 0; j < 14; j++) adr[j] = bus.mc_ADR[j*8 + 2*k];

            if (!act_n) code = C_ACT;
            else begin
                case (rcw)
                    3'b000:  code = C_MRS;
                    3'b001:  code = cke ? C_REF : C_SRE;
                    3'b010:  code = adr[10] ? C_PREA : C_PRE;
                    3'b011:  code = C_RSVD;
                    3'b100:  code = C_WR;
                    3'b101:  code = C_RD;
                    3'b110:  code = C_ZQC;
                    default: code = C_DES;
                endcase
            end

            srx_edge = cke && !cke_prev && sr_d;
            if (srx_edge) begin
                sr_d  = 1'b0;
                srx_d = 1'b1;
            end

            if (!cs_n) begin
                vld_d[k]         = 1'b1;
                code_d[4*k +: 4] = code;
                if (code != C_DES) begin
                    if (code != C_MRS && (mrs_any || mod_cnt_q != 16'd0)) set_tmod = 1'b1;
                    if (xs_cnt_q != 16'd0 || srx_seen) set_txs = 1'b1;
                    if (!cke && sr_d) set_sr = 1'b1;
                end
                if (code == C_MRS) begin
                    mrs_any = 1'b1;
                    if (!bg0 && ba == 2'b01) mr1_d = adr;
                end
                if (code == C_SRE) sr_d = 1'b1;
            end

            if (srx_edge) srx_seen = 1'b1;
            cke_prev = cke;
        end
        cke_last_d = cke_prev;

        if (mrs_any)                mod_cnt_d = 16'(T_MOD);
        else if (mod_cnt_q != 16'd0) mod_cnt_d = mod_cnt_q - 16'd1;
        else                        mod_cnt_d = 16'd0;

        if (srx_d)                  xs_cnt_d = 16'(T_XS);
        else if (xs_cnt_q != 16'd0) xs_cnt_d = xs_cnt_q - 16'd1;
        else                        xs_cnt_d = 16'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_q   <= '0;
            cmd_code_q  <= '0;
            srx_q       <= 1'b0;
            sr_q        <= 1'b0;
            mr1_q       <= MR1_RST;
            viol_tmod_q <= 1'b0;
            viol_txs_q  <= 1'b0;
            viol_sr_q   <= 1'b0;
            mod_cnt_q   <= '0;
            xs_cnt_q    <= '0;
            cke_last_q  <= 1'b1;
        end else begin
            cmd_vld_q   <= vld_d;
            cmd_code_q  <= code_d;
            srx_q       <= srx_d;
            sr_q        <= sr_d;
            mr1_q       <= mr1_d;
            viol_tmod_q <= set_tmod | (viol_tmod_q & ~viol_clr);
            viol_txs_q  <= set_txs  | (viol_txs_q  & ~viol_clr);
            viol_sr_q   <= set_sr   | (viol_sr_q   & ~viol_clr);
            mod_cnt_q   <= mod_cnt_d;
            xs_cnt_q    <= xs_cnt_d;
            cke_last_q  <= cke_last_d;
        end
    end

    assign cmd_vld   = cmd_vld_q;
    assign cmd_code  = cmd_code_q;
    assign srx_pulse = srx_q;
    assign sr_active = sr_q;
    assign dll_on    = mr1_q[0];
    assign viol_tmod = viol_tmod_q;
    assign viol_txs  = viol_txs_q;
    assign viol_sr   = viol_sr_q;
endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// tb/tb_ddr4_cmd_monitor.sv - directed self-checking bench for ddr4_cmd_monitor
module tb_ddr4_cmd_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        viol_clr = 1'b0;
    logic [3:0]  cmd_vld;
    logic [15:0] cmd_code;
    logic        srx_pulse, sr_active, dll_on, viol_tmod, viol_txs, viol_sr;
    logic [13:0] mr1_q;
    int checks = 0;
    int errors = 0;

    ddr4_cmd_monitor_if bus_if ();

    ddr4_cmd_monitor dut (
        .clk(clk), .rst(rst), .bus(bus_if), .viol_clr(viol_clr),
        .cmd_vld(cmd_vld), .cmd_code(cmd_code), .srx_pulse(srx_pulse),
        .sr_active(sr_active), .mr1_q(mr1_q), .dll_on(dll_on),
        .viol_tmod(viol_tmod), .viol_txs(viol_txs), .viol_sr(viol_sr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic cke_lvl);
        bus_if.mc_CS_n  = '1;
        bus_if.mc_ACT_n = '1;
        bus_if.mc_ADR   = '1;
        bus_if.mc_BA    = '0;
        bus_if.mc_BG    = '0;
        bus_if.mc_CKE   = {8{cke_lvl}};
    endtask

    task automatic put(input int k, input logic act_n, input logic [2:0] rcw, input logic cke,
                       input logic [1:0] ba, input logic bg0, input logic [13:0] a);
        for (int b = 0; b < 2; b++) begin
            int s;
            s = 2*k + b;
            bus_if.mc_CS_n[s]       = 1'b0;
            bus_if.mc_ACT_n[s]      = act_n;
            bus_if.mc_ADR[16*8 + s] = rcw[2];
            bus_if.mc_ADR[15*8 + s] = rcw[1];
            bus_if.mc_ADR[14*8 + s] = rcw[0];
            for (int j = 0; j < 14; j++) bus_if.mc_ADR[j*8 + s] = a[j];
            bus_if.mc_CKE[s]        = cke;
            bus_if.mc_BA[s]         = ba[0];
            bus_if.mc_BA[8 + s]     = ba[1];
            bus_if.mc_BG[s]         = bg0;
        end
    endtask

    task automatic clear_viol(input logic cke_lvl);
        idle(cke_lvl);
        viol_clr = 1'b1;
        step();
        viol_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle(1'b1);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (cmd_vld !== 4'h0) begin errors++; $display("FAIL reset_vld got %h want 0", cmd_vld); end
        checks++; if (cmd_code !== 16'h0) begin errors++; $display("FAIL reset_code got %h want 0", cmd_code); end
        checks++; if (mr1_q !== 14'h0001 || dll_on !== 1'b1) begin errors++; $display("FAIL reset_mr1 got %h/%b want 0001/1", mr1_q, dll_on); end
        checks++; if ({srx_pulse, sr_active, viol_tmod, viol_txs, viol_sr} !== 5'b0) begin errors++;
            $display("FAIL reset_flags got %b want 00000", {srx_pulse, sr_active, viol_tmod, viol_txs, viol_sr}); end
    endtask

    task automatic test_decode();
        idle(1'b1); put(0, 1'b1, 3'b010, 1'b1, 2'b00, 1'b0, 14'h0400); step();
        checks++; if (cmd_vld !== 4'b0001 || cmd_code !== 16'h0003) begin errors++;
            $display("FAIL prea got vld=%b code=%h want 0001/0003", cmd_vld, cmd_code); end
        idle(1'b1); put(2, 1'b1, 3'b111, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (cmd_vld !== 4'b0100 || cmd_code !== 16'h0000) begin errors++;
            $display("FAIL des got vld=%b code=%h want 0100/0000", cmd_vld, cmd_code); end
        idle(1'b1); step();
        checks++; if (cmd_vld !== 4'b0000) begin errors++; $display("FAIL idle_vld got %b want 0000", cmd_vld); end
    endtask

    task automatic test_mr1_tmod();
        idle(1'b1); put(0, 1'b1, 3'b000, 1'b1, 2'b01, 1'b0, 14'h0300); step();
        checks++; if (mr1_q !== 14'h0300 || dll_on !== 1'b0) begin errors++;
            $display("FAIL mr1_load got %h/%b want 0300/0", mr1_q, dll_on); end
        idle(1'b1); repeat (9) step();
        checks++; if (viol_tmod !== 1'b0) begin errors++; $display("FAIL tmod_quiet got %b want 0", viol_tmod); end
        put(0, 1'b1, 3'b010, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_tmod !== 1'b1) begin errors++; $display("FAIL tmod_pre10 got %b want 1", viol_tmod); end
        clear_viol(1'b1);
        checks++; if (viol_tmod !== 1'b0) begin errors++; $display("FAIL tmod_clr got %b want 0", viol_tmod); end
        // MR0 write: restarts tMOD but must not touch the MR1 image
        idle(1'b1); put(0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 14'h0001); step();
        checks++; if (mr1_q !== 14'h0300) begin errors++; $display("FAIL mr0_ignored got %h want 0300", mr1_q); end
        idle(1'b1); repeat (23) step();
        put(0, 1'b1, 3'b010, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_tmod !== 1'b1) begin errors++; $display("FAIL tmod_pre24 got %b want 1", viol_tmod); end
        clear_viol(1'b1);
        idle(1'b1); put(0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 14'h0001); step();
        idle(1'b1); repeat (24) step();
        put(0, 1'b1, 3'b010, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_tmod !== 1'b0) begin errors++; $display("FAIL tmod_pre25 got %b want 0", viol_tmod); end
        idle(1'b1); put(0, 1'b1, 3'b000, 1'b1, 2'b00, 1'b0, 14'h0001);
        put(1, 1'b1, 3'b010, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_tmod !== 1'b1) begin errors++; $display("FAIL tmod_same_cycle got %b want 1", viol_tmod); end
        clear_viol(1'b1);
        idle(1'b1); repeat (30) step();
    endtask

    task automatic test_sr_txs();
        idle(1'b0); put(0, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (sr_active !== 1'b1 || cmd_code !== 16'h0007 || viol_sr !== 1'b0) begin errors++;
            $display("FAIL sre got sr=%b code=%h vsr=%b want 1/0007/0", sr_active, cmd_code, viol_sr); end
        idle(1'b0); repeat (299) step();
        checks++; if (sr_active !== 1'b1 || srx_pulse !== 1'b0) begin errors++;
            $display("FAIL sr_hold got sr=%b srx=%b want 1/0", sr_active, srx_pulse); end
        idle(1'b1); step();
        checks++; if (srx_pulse !== 1'b1 || sr_active !== 1'b0) begin errors++;
            $display("FAIL srx got srx=%b sr=%b want 1/0", srx_pulse, sr_active); end
        step();
        checks++; if (srx_pulse !== 1'b0) begin errors++; $display("FAIL srx_one_cycle got %b want 0", srx_pulse); end
        repeat (498) step();
        put(0, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_txs !== 1'b1 || cmd_code !== 16'h0006) begin errors++;
            $display("FAIL txs_ref500 got v=%b code=%h want 1/0006", viol_txs, cmd_code); end
        clear_viol(1'b1);
        idle(1'b1); repeat (499) step();
        put(0, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_txs !== 1'b0) begin errors++; $display("FAIL txs_ref1001 got %b want 0", viol_txs); end
    endtask

    task automatic test_viol_sr();
        idle(1'b0); put(0, 1'b1, 3'b001, 1'b0, 2'b00, 1'b0, 14'h0000); step();
        idle(1'b0); put(0, 1'b1, 3'b101, 1'b0, 2'b00, 1'b0, 14'h0000); step();
        checks++; if (viol_sr !== 1'b1) begin errors++; $display("FAIL viol_sr got %b want 1", viol_sr); end
        idle(1'b0); put(0, 1'b1, 3'b101, 1'b0, 2'b00, 1'b0, 14'h0000);
        viol_clr = 1'b1; step(); viol_clr = 1'b0;
        checks++; if (viol_sr !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", viol_sr); end
        clear_viol(1'b0);
        checks++; if ({viol_tmod, viol_txs, viol_sr} !== 3'b000) begin errors++;
            $display("FAIL clr_all got %b want 000", {viol_tmod, viol_txs, viol_sr}); end
    endtask

    task automatic test_reset_abort();
        idle(1'b1); step();
        checks++; if (srx_pulse !== 1'b1) begin errors++; $display("FAIL abort_srx got %b want 1", srx_pulse); end
        repeat (199) step();
        rst = 1'b1; step(); rst = 1'b0;
        put(0, 1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 14'h0000); step();
        checks++; if ({viol_tmod, viol_txs, viol_sr, sr_active} !== 4'b0000) begin errors++;
            $display("FAIL abort_flags got %b want 0000", {viol_tmod, viol_txs, viol_sr, sr_active}); end
        checks++; if (mr1_q !== 14'h0001 || cmd_code !== 16'h0006) begin errors++;
            $display("FAIL abort_mr1 got %h code=%h want 0001/0006", mr1_q, cmd_code); end
    endtask

    task automatic test_back_to_back();
        idle(1'b1);
        put(0, 1'b0, 3'b111, 1'b1, 2'b00, 1'b0, 14'h0000);
        put(1, 1'b1, 3'b101, 1'b1, 2'b00, 1'b0, 14'h0000);
        put(2, 1'b1, 3'b100, 1'b1, 2'b00, 1'b0, 14'h0000);
        put(3, 1'b1, 3'b110, 1'b1, 2'b00, 1'b0, 14'h0000);
        step();
        checks++; if (cmd_vld !== 4'hF || cmd_code !== 16'h9541) begin errors++;
            $display("FAIL four_slots got vld=%h code=%h want F/9541", cmd_vld, cmd_code); end
    endtask

    initial begin
        idle(1'b1);
        test_reset();
        test_decode();
        test_mr1_tmod();
        test_sr_txs();
        test_viol_sr();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
